// File: rtl/bnn_seq_ctrl.sv
// rtl/bnn_seq_ctrl.sv - time-multiplexed two-layer BNN sequencer with nibble-serial weight loader
// Optional debug taps (dbg_idx, dbg_sum) are compiled in only when BNN_DBG_EN is defined.
module bnn_seq_ctrl #(
   parameter int NUM_L1 = 4,
   parameter int NUM_L2 = 4,
   parameter int IN_W   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_data,
   output logic            in_ready,
   input  logic            cfg_en,
   input  logic [3:0]      cfg_nibble,
   output logic            cfg_ready,
   output logic            out_valid,
   output logic [7:0]      out_data,
   input  logic            out_ready,
   output logic            busy
`ifdef BNN_DBG_EN
   ,
   output logic [2:0]      dbg_idx,
   output logic [3:0]      dbg_sum
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   localparam logic [IN_W-1:0] W_RST [8] = '{8'hF0, 8'h0F, 8'h3C, 8'hC3,
                                            8'hF0, 8'h0F, 8'h3C, 8'hC3};

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [IN_W-1:0] x_q, x_d;
   logic [3:0]      l1_q, l1_d;
   logic [3:0]      l2_q, l2_d;
   logic [IN_W-1:0] w_q [8];
   logic [IN_W-1:0] w_d [8];
   logic [3:0]      th_q [8];
   logic [3:0]      th_d [8];
   logic [1:0]      phase_q, phase_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [3:0]      lo_q, lo_d;
   logic [3:0]      hi_q, hi_d;

   logic [IN_W-1:0] match_vec;
   logic [3:0]      sum;
   logic            fire;
   logic            is_l1;

   // One shared XNOR-popcount engine; layer 2 only looks at the upper weight nibble.
   always_comb begin
      is_l1     = (idx_q < 3'(NUM_L1));
      match_vec = '0;
      if (is_l1) begin
         match_vec = ~(x_q ^ w_q[idx_q]);
      end else begin
         match_vec[3:0] = ~(l1_q ^ w_q[idx_q][IN_W-1 -: 4]);
      end
      sum = '0;
      for (int i = 0; i < IN_W; i++) begin
         sum = sum + {3'b000, match_vec[i]};
      end
      fire = (sum >= th_q[idx_q]);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      x_d     = x_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      w_d     = w_q;
      th_d    = th_q;
      phase_d = phase_q;
      ptr_d   = ptr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         IDLE: begin
            if (cfg_en) begin
               // Configuration takes priority over an offered input vector.
               case (phase_q)
                  2'd0: begin
                     lo_d    = cfg_nibble;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     hi_d    = cfg_nibble;
                     phase_d = 2'd2;
                  end
                  default: begin
                     w_d[ptr_q]  = {hi_q, lo_q};
                     th_d[ptr_q] = cfg_nibble;
                     ptr_d       = ptr_q + 3'd1;
                     phase_d     = 2'd0;
                  end
               endcase
            end else if (in_valid && phase_q == 2'd0) begin
               x_d     = in_data;
               l1_d    = '0;
               l2_d    = '0;
               idx_d   = '0;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (is_l1) l1_d[idx_q[1:0]] = fire;
            else       l2_d[idx_q[1:0]] = fire;
            if (idx_q == 3'(NUM_L1 + NUM_L2 - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         x_q     <= '0;
         l1_q    <= '0;
         l2_q    <= '0;
         w_q     <= W_RST;
         for (int i = 0; i < 8; i++) th_q[i] <= 4'd5;
         phase_q <= '0;
         ptr_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         l1_q    <= l1_d;
         l2_q    <= l2_d;
         w_q     <= w_d;
         th_q    <= th_d;
         phase_q <= phase_d;
         ptr_q   <= ptr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !cfg_en && (phase_q == 2'd0);
   assign cfg_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = {l2_q, l1_q};

`ifdef BNN_DBG_EN
   assign dbg_idx = (state_q == EVAL) ? idx_q : 3'd0;
   assign dbg_sum = (state_q == EVAL) ? sum : 4'd0;
`endif

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb/tb_bnn_seq_ctrl.sv - directed self-checking bench for bnn_seq_ctrl
module tb_bnn_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       cfg_en = 1'b0;
   logic [3:0] cfg_nibble = 4'h0;
   logic       cfg_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic       busy;

   int checks = 0;
   int failures = 0;

   bnn_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cfg_en(cfg_en), .cfg_nibble(cfg_nibble), .cfg_ready(cfg_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      cfg_en = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send_trip(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      cfg_en = 1'b1;
      cfg_nibble = a; tick();
      cfg_nibble = b; tick();
      cfg_nibble = c; tick();
      cfg_en = 1'b0;
   endtask

   // Offers x, waits for out_valid, captures result and latency, then completes the handshake.
   task automatic run_vec(input logic [7:0] x, output logic [7:0] res, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      in_valid = 1'b1;
      in_data = x;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      res = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
   endtask

   task automatic test_defaults();
      logic [7:0] res; int lat;
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h01) begin failures++; $display("FAIL def_f0 got=%h exp=01", res); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL def_latency got=%0d exp=8", lat); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL def_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] res; int lat;
      run_vec(8'h0F, res, lat);
      checks++; if (res !== 8'h02) begin failures++; $display("FAIL b2b_0f got=%h exp=02", res); end
      run_vec(8'h3C, res, lat);
      checks++; if (res !== 8'h04) begin failures++; $display("FAIL b2b_3c got=%h exp=04", res); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
   endtask

   task automatic test_config();
      logic [7:0] res; int lat;
      do_reset();
      in_valid = 1'b1; in_data = 8'hF0;
      send_trip(4'h0, 4'hF, 4'h5);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cfg_wins got busy=%b exp=0", busy); end
      send_trip(4'hF, 4'h0, 4'h5);
      send_trip(4'hC, 4'h3, 4'h5);
      send_trip(4'h3, 4'hC, 4'h5);
      send_trip(4'h0, 4'h1, 4'h4);
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h11) begin failures++; $display("FAIL cfg_n4 got=%h exp=11", res); end
      cfg_en = 1'b1;
      cfg_nibble = 4'h0; tick();
      cfg_nibble = 4'h0; tick();
      cfg_en = 1'b0;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfg_partial_in_ready got=%b exp=0", in_ready); end
      in_valid = 1'b1; in_data = 8'hF0;
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cfg_partial_block got busy=%b exp=0", busy); end
      cfg_en = 1'b1; cfg_nibble = 4'h0; tick(); cfg_en = 1'b0;
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h31) begin failures++; $display("FAIL cfg_ptr5 got=%h exp=31", res); end
   endtask

   task automatic test_thresh0();
      logic [7:0] res; int lat;
      do_reset();
      send_trip(4'h0, 4'hF, 4'h5);
      send_trip(4'hF, 4'h0, 4'h0);
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h03) begin failures++; $display("FAIL th0 got=%h exp=03", res); end
   endtask

   task automatic test_backpressure();
      int lat;
      do_reset();
      in_valid = 1'b1; in_data = 8'hF0;
      tick();
      in_data = 8'hFF;
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", lat); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=01 rdy=0", i, out_valid, out_data, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got v=%b busy=%b exp 0 0", out_valid, busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_cfg_during_eval();
      logic [7:0] res; int lat;
      do_reset();
      in_valid = 1'b1; in_data = 8'hF0;
      tick();
      in_valid = 1'b0;
      cfg_en = 1'b1;
      cfg_nibble = 4'hF; tick();
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL eval_cfg_ready got=%b exp=0", cfg_ready); end
      cfg_nibble = 4'hF; tick();
      cfg_nibble = 4'h0; tick();
      cfg_en = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (out_data !== 8'h01) begin failures++; $display("FAIL eval_cfg_result got=%h exp=01", out_data); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL eval_cfg_phase got in_ready=%b exp=1", in_ready); end
      send_trip(4'hF, 4'h0, 4'h5);
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h00) begin failures++; $display("FAIL eval_cfg_ptr got=%h exp=00", res); end
   endtask

   task automatic test_reset_mid_eval();
      logic [7:0] res; int lat;
      in_valid = 1'b1; in_data = 8'hF0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst got v=%b busy=%b exp 0 0", out_valid, busy); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", out_data); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
      run_vec(8'hF0, res, lat);
      checks++; if (res !== 8'h01) begin failures++; $display("FAIL mid_rst_defaults got=%h exp=01", res); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL mid_rst_latency got=%0d exp=8", lat); end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_back_to_back();
      test_config();
      test_thresh0();
      test_backpressure();
      test_cfg_during_eval();
      test_reset_mid_eval();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
